// File: rtl/axil_rr_master_arbiter_pkg.sv
// axil_rr_master_arbiter_pkg: shared response codes, FSM states and protection default
package axil_rr_master_arbiter_pkg;
  typedef enum logic [1:0] {OKAY, EXOKAY, SLVERR, DECERR} resp_t;
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA} state_t;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;
endpackage

// File: rtl/axil_rr_master_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting just after the last granted index
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  localparam int IW = $clog2(N);
  function automatic logic [IW-1:0] slot(input logic [IW-1:0] p, input int i);
    int v = int'(p) + i;
    return IW'(v >= N ? v - N : v);
  endfunction
  // scan farthest-first so the nearest requester after ptr overwrites and wins
  always_comb begin
    idx = '0;
    for (int i = N; i >= 1; i--) if (req[slot(ptr, i)]) idx = slot(ptr, i);
    any = |req;
    grant = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/axil_rr_master_arbiter.sv
// axil_rr_master_arbiter: round-robin sharing of one AXI4-Lite master port, one transaction in flight
module axil_rr_master_arbiter
  import axil_rr_master_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_write,
  input  logic [N_REQ*AW-1:0]       req_addr,
  input  logic [N_REQ*DW-1:0]       req_wdata,
  input  logic [N_REQ*(DW/8)-1:0]   req_wstrb,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DW-1:0]             rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic [AW-1:0]             m_awaddr,
  output logic [2:0]                m_awprot,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [DW-1:0]             m_wdata,
  output logic [DW/8-1:0]           m_wstrb,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  output logic [AW-1:0]             m_araddr,
  output logic [2:0]                m_arprot,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [DW-1:0]             m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rvalid,
  output logic                      m_rready
);
  localparam int IW = $clog2(N_REQ);
  state_t state, state_nx;
  logic [N_REQ-1:0] win;
  logic [IW-1:0] win_id, ptr;
  logic any, grant, aw_pend, w_pend, aw_done, w_done;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  rr_arbiter #(.N(N_REQ)) u_arb (
    .req  (req_valid),
    .ptr  (ptr),
    .grant(win),
    .idx  (win_id),
    .any  (any)
  );
  assign grant     = state == IDLE && any;
  assign req_ready = grant ? win : '0;
  assign aw_done   = !aw_pend || m_awready;
  assign w_done    = !w_pend || m_wready;
  assign busy      = state != IDLE;
  assign m_awaddr  = addr;
  assign m_araddr  = addr;
  assign m_wdata   = wdata;
  assign m_wstrb   = wstrb;
  assign m_awprot  = PROT_DEFAULT;
  assign m_arprot  = PROT_DEFAULT;
  assign m_awvalid = aw_pend;
  assign m_wvalid  = w_pend;
  assign m_bready  = state == WR_RESP;
  assign m_arvalid = state == RD_ADDR;
  assign m_rready  = state == RD_DATA;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any) state_nx = req_write[win_id] ? WR_ADDR : RD_ADDR;
      WR_ADDR: if (aw_done && w_done) state_nx = WR_RESP;
      WR_RESP: if (m_bvalid) state_nx = IDLE;
      RD_ADDR: if (m_arready) state_nx = RD_DATA;
      RD_DATA: if (m_rvalid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // aw and w retire independently; each flag drops on its own handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= IW'(N_REQ - 1);
      grant_id  <= '0;
      addr      <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      aw_pend   <= 1'b0;
      w_pend    <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_resp  <= OKAY;
    end else begin
      rsp_valid <= '0;
      if (state == WR_ADDR && m_awready) aw_pend <= 1'b0;
      if (state == WR_ADDR && m_wready) w_pend <= 1'b0;
      if (grant) begin
        ptr      <= win_id;
        grant_id <= win_id;
        addr     <= req_addr[int'(win_id)*AW +: AW];
        wdata    <= req_wdata[int'(win_id)*DW +: DW];
        wstrb    <= req_wstrb[int'(win_id)*(DW/8) +: DW/8];
        aw_pend  <= req_write[win_id];
        w_pend   <= req_write[win_id];
      end
      if (state == WR_RESP && m_bvalid) begin
        rsp_valid <= N_REQ'(1) << grant_id;
        rsp_rdata <= '0;
        rsp_resp  <= m_bresp;
      end
      if (state == RD_DATA && m_rvalid) begin
        rsp_valid <= N_REQ'(1) << grant_id;
        rsp_rdata <= m_rdata;
        rsp_resp  <= m_rresp;
      end
    end
  end
endmodule

// File: tb/tb_axil_rr_master_arbiter.sv
// tb_axil_rr_master_arbiter: directed checks of arbitration, AXI handshakes and responses against a GPIO/BRAM slave model
module tb_axil_rr_master_arbiter;
  localparam int N = 4, AW = 32, DW = 32;
  localparam logic [31:0] GPIO = 32'h4120_0000;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [N-1:0] req_valid = '0, req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N*4-1:0] req_wstrb = '0;
  logic [N-1:0] req_ready, rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_resp, grant_id;
  logic busy;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0] m_awprot, m_arprot;
  logic [3:0] m_wstrb;
  logic [1:0] m_bresp, m_rresp;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rready;
  axil_rr_master_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .busy(busy), .grant_id(grant_id),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );
  logic [31:0] bram [256];
  logic [31:0] gpio = '0, awa = '0, wd = '0, ca, cw;
  logic [3:0] ws = '0, cs;
  logic got_aw, got_w, aw_hs, w_hs;
  int aw_dly = 0, b_dly = 0, aw_cnt, b_cnt;
  assign aw_hs = m_awvalid && m_awready;
  assign w_hs  = m_wvalid && m_wready;
  assign ca = aw_hs ? m_awaddr : awa;
  assign cw = w_hs ? m_wdata : wd;
  assign cs = w_hs ? m_wstrb : ws;
  function automatic logic [1:0] dec(input logic [31:0] a);
    return a == GPIO ? 2'b00 : a[31:12] == 20'h41200 ? 2'b10 : a[31:12] == 20'h40000 ? 2'b00 : 2'b11;
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = d[8*b +: 8];
    return o;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      m_awready <= 0; m_wready <= 0; m_bvalid <= 0; m_bresp <= 0;
      m_arready <= 0; m_rvalid <= 0; m_rdata <= 0; m_rresp <= 0;
      got_aw <= 0; got_w <= 0; aw_cnt <= 0; b_cnt <= 0;
    end else begin
      m_awready <= 0; m_wready <= 0; m_arready <= 0;
      if (m_bvalid && m_bready) m_bvalid <= 0;
      if (m_rvalid && m_rready) m_rvalid <= 0;
      if (m_awvalid && !m_awready) begin
        if (aw_cnt == aw_dly) begin m_awready <= 1; aw_cnt <= 0; end
        else aw_cnt <= aw_cnt + 1;
      end
      if (m_wvalid && !m_wready) m_wready <= 1;
      if (aw_hs) begin got_aw <= 1; awa <= m_awaddr; end
      if (w_hs) begin got_w <= 1; wd <= m_wdata; ws <= m_wstrb; end
      if ((got_aw || aw_hs) && (got_w || w_hs)) begin
        if (b_cnt == b_dly) begin
          m_bvalid <= 1; m_bresp <= dec(ca);
          if (ca == GPIO) gpio <= merge(gpio, cw, cs);
          else if (ca[31:12] == 20'h40000) bram[ca[9:2]] <= merge(bram[ca[9:2]], cw, cs);
          got_aw <= 0; got_w <= 0; b_cnt <= 0;
        end else b_cnt <= b_cnt + 1;
      end
      if (m_arvalid && !m_arready) m_arready <= 1;
      if (m_arvalid && m_arready) begin
        m_rvalid <= 1; m_rresp <= dec(m_araddr);
        m_rdata <= m_araddr == GPIO ? gpio : m_araddr[31:12] == 20'h40000 ? bram[m_araddr[9:2]] :
                   m_araddr[31:12] == 20'h41200 ? 32'h0 : 32'hDEAD_BEEF;
      end
    end
  end
  int total = 0, bad = 0;
  int r_lat, r_awv, r_wv, r_unst;
  logic [2:0] r_first;
  logic [N-1:0] r_vec, r_extra;
  logic [31:0] r_rdata;
  logic [1:0] r_resp;
  int ord [5] = '{0, 1, 2, 3, 0};
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic run_txn(input int i, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int k;
    req_write[i] = w; req_addr[i*AW +: AW] = a; req_wdata[i*DW +: DW] = d; req_wstrb[i*4 +: 4] = s;
    req_valid[i] = 1'b1;
    #1;
    for (k = 0; k < 40 && !req_ready[i]; k++) tick;
    check("ready_onehot", req_ready, 64'(1) << i);
    r_awv = 0; r_wv = 0; r_unst = 0; r_first = '0;
    for (k = 1; k <= 60; k++) begin
      tick;
      if (k == 1) begin req_valid[i] = 1'b0; r_first = {m_awvalid, m_wvalid, m_arvalid}; end
      r_awv += int'(m_awvalid);
      r_wv  += int'(m_wvalid);
      if (m_awvalid && m_awaddr !== a) r_unst++;
      if (m_wvalid && (m_wdata !== d || m_wstrb !== s)) r_unst++;
      if (m_arvalid && m_araddr !== a) r_unst++;
      if (|rsp_valid) break;
    end
    r_lat = k; r_vec = rsp_valid; r_rdata = rsp_rdata; r_resp = rsp_resp;
    tick;
    r_extra = rsp_valid;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    int rc;
    for (int j = 0; j < 256; j++) bram[j] = (j >= 64 && j < 68) ? 32'h1000_0000 + 32'(j - 64) : 32'h0;
    repeat (3) tick;
    check("rst_outs", {busy, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid, req_ready, rsp_resp}, 0);
    check("rst_gid", {grant_id, rsp_rdata, m_awaddr}, 0);
    rst = 0;
    tick;
    for (int j = 0; j < N; j++) begin
      req_write[j] = 0;
      req_addr[j*AW +: AW] = 32'h4000_0100 + 32'(4*j);
    end
    req_valid = '1;
    #1;
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < 40 && !(|req_ready); k++) tick;
      check("t3_ready", req_ready, 64'(1) << ord[g]);
      tick;
      check("t3_gid", grant_id, ord[g]);
      if (g > 0) req_valid[ord[g]] = 1'b0;
      for (int k = 0; k < 40 && !(|rsp_valid); k++) tick;
      check("t3_rsp", rsp_valid, 64'(1) << ord[g]);
      check("t3_data", rsp_rdata, 32'h1000_0000 + 32'(ord[g]));
    end
    tick;
    run_txn(0, 1, GPIO, 32'h1111_1111, 4'hF);
    check("t1_first", r_first, 3'b110);
    check("t1_lat", r_lat, 4);
    check("t1_rsp", r_vec, 4'b0001);
    check("t1_resp", r_resp, 2'b00);
    check("t1_rdata", r_rdata, 0);
    check("t1_gpio", gpio, 32'h1111_1111);
    check("t1_awcyc", r_awv, 2);
    run_txn(1, 1, 32'h4000_0000, 32'hABCD_1854, 4'hF);
    check("t2w_rsp", r_vec, 4'b0010);
    check("t2w_resp", r_resp, 2'b00);
    run_txn(1, 0, 32'h4000_0000, 32'h0, 4'h0);
    check("t2r_first", r_first, 3'b001);
    check("t2r_lat", r_lat, 4);
    check("t2r_data", r_rdata, 32'hABCD_1854);
    check("t2r_resp", r_resp, 2'b00);
    aw_dly = 3; b_dly = 5;
    run_txn(2, 1, 32'h4000_0008, 32'h5A5A_A5A5, 4'h3);
    check("t4_awcyc", r_awv, 5);
    check("t4_wcyc", r_wv, 2);
    check("t4_stable", r_unst, 0);
    check("t4_lat", r_lat, 12);
    check("t4_rsp", r_vec, 4'b0100);
    check("t4_single", r_extra, 0);
    check("t4_bram", bram[2], 32'h0000_A5A5);
    aw_dly = 0; b_dly = 0;
    run_txn(3, 0, 32'h5000_0000, 32'h0, 4'h0);
    check("t5_resp", r_resp, 2'b11);
    check("t5_data", r_rdata, 32'hDEAD_BEEF);
    check("t5_rsp", r_vec, 4'b1000);
    run_txn(0, 1, 32'h4120_0004, 32'h2222_2222, 4'hF);
    check("slverr_resp", r_resp, 2'b10);
    check("slverr_gpio", gpio, 32'h1111_1111);
    b_dly = 5;
    req_write[1] = 1; req_addr[AW +: AW] = 32'h4000_0010; req_wdata[DW +: DW] = 32'h7777_7777; req_wstrb[7:4] = 4'hF;
    req_valid[1] = 1;
    #1;
    for (int k = 0; k < 40 && !req_ready[1]; k++) tick;
    tick;
    req_valid[1] = 0;
    for (int k = 0; k < 20 && !m_bready; k++) tick;
    check("t6_in_wresp", {m_bready, busy}, 2'b11);
    rst = 1;
    tick;
    check("t6_rst", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, busy, rsp_valid}, 0);
    rst = 0;
    b_dly = 0;
    rc = 0;
    for (int k = 0; k < 8; k++) begin tick; rc += int'(|rsp_valid); end
    check("t6_norsp", rc, 0);
    for (int j = 0; j < N; j++) begin
      req_write[j] = 0;
      req_addr[j*AW +: AW] = 32'h4000_0100 + 32'(4*j);
    end
    req_valid = '1;
    #1;
    check("t6_first", req_ready, 4'b0001);
    tick;
    check("t6_gid", grant_id, 0);
    req_valid = '0;
    for (int k = 0; k < 40 && !(|rsp_valid); k++) tick;
    check("t6_rsp", rsp_valid, 4'b0001);
    check("t6_data", rsp_rdata, 32'h1000_0000);
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
